// File: rtl/dyn_branch_predictor.sv
// Direct-mapped BTB+BHT dynamic branch predictor with saturating counters, an init sequencer
// that clears the table after reset or flush, and saturating lookup/mispredict statistics.
module dyn_branch_predictor #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned STAT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  output logic              ready,
  input  logic              lk_valid,
  input  logic [31:0]       lk_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_mispred,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] WeakTaken = CNT_W'(1) << (CNT_W - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
  logic [STAT_W-1:0]  stat_lookups_q, stat_lookups_d;
  logic [STAT_W-1:0]  stat_mispred_q, stat_mispred_d;

  logic               valid_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q   [ENTRIES];
  logic [CNT_W-1:0]   cnt_q   [ENTRIES];
  logic [29:0]        tgt_q   [ENTRIES];

  logic [IDX_W-1:0]   lk_idx, upd_idx;
  logic [TAG_W-1:0]   lk_tag, upd_tag;
  logic               lk_hit, upd_hit, upd_we;
  logic [CNT_W-1:0]   cnt_upd;
  logic               unused_bits;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_bits = ^{lk_pc, upd_pc, upd_target[1:0]};

  assign ready        = (state_q == StRun);
  assign stat_lookups = stat_lookups_q;
  assign stat_mispred = stat_mispred_q;

  // Lookup reads pre-update contents; no bypass from the write port.
  always_comb begin
    lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = ready && lk_valid && lk_hit && cnt_q[lk_idx][CNT_W-1];
    pred_target = pred_taken ? {tgt_q[lk_idx], 2'b00} : 32'h0;
  end

  always_comb begin
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_we  = ready && upd_valid && !rst && !flush;
    cnt_upd = cnt_q[upd_idx];
    if (!upd_hit) begin
      cnt_upd = WeakTaken;
    end else if (upd_taken) begin
      if (cnt_q[upd_idx] != '1) cnt_upd = cnt_q[upd_idx] + 1'b1;
    end else begin
      if (cnt_q[upd_idx] != '0) cnt_upd = cnt_q[upd_idx] - 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    clr_idx_d      = clr_idx_q;
    stat_lookups_d = stat_lookups_q;
    stat_mispred_d = stat_mispred_q;
    if (state_q == StInit) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == IDX_W'(ENTRIES - 1)) begin
        state_d   = StRun;
        clr_idx_d = '0;
      end
    end else begin
      if (lk_valid && stat_lookups_q != '1) stat_lookups_d = stat_lookups_q + 1'b1;
      if (upd_valid && upd_mispred && stat_mispred_q != '1) begin
        stat_mispred_d = stat_mispred_q + 1'b1;
      end
    end
    if (flush) begin
      state_d   = StInit;
      clr_idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StInit;
      clr_idx_q      <= '0;
      stat_lookups_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      state_q        <= state_d;
      clr_idx_q      <= clr_idx_d;
      stat_lookups_q <= stat_lookups_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end

  // Miss+not-taken leaves the entry untouched; miss+taken overwrites whatever aliased there.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      valid_q[clr_idx_q] <= 1'b0;
    end else if (upd_we && (upd_hit || upd_taken)) begin
      valid_q[upd_idx] <= 1'b1;
      tag_q[upd_idx]   <= upd_tag;
      cnt_q[upd_idx]   <= cnt_upd;
      if (upd_taken) tgt_q[upd_idx] <= upd_target[31:2];
    end
  end

endmodule

// File: tb/tb_dyn_branch_predictor.sv
// Directed self-checking bench for dyn_branch_predictor (STAT_W reduced to 8 to reach saturation).
module tb_dyn_branch_predictor;

  logic        clk = 1'b0;
  logic        rst, flush, ready;
  logic        lk_valid, pred_taken;
  logic [31:0] lk_pc, pred_target;
  logic        upd_valid, upd_taken, upd_mispred;
  logic [31:0] upd_pc, upd_target;
  logic [7:0]  stat_lookups, stat_mispred;

  int tests = 0;
  int fails = 0;
  int exp_lk = 0;

  always #5 clk = ~clk;

  dyn_branch_predictor #(
    .ENTRIES(64), .CNT_W(2), .TAG_W(8), .STAT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .ready(ready),
    .lk_valid(lk_valid), .lk_pc(lk_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispred(upd_mispred), .stat_lookups(stat_lookups), .stat_mispred(stat_mispred)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (lk_valid) exp_lk++;
    lk_valid  = 1'b0;
    upd_valid = 1'b0;
    flush     = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic lk(input logic [31:0] pc);
    lk_valid = 1'b1;
    lk_pc    = pc;
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_taken   = taken;
    upd_target  = tgt;
    upd_mispred = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int n = 0;
    int bad = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    lk_valid = 1'b1;
    lk_pc    = 32'h100;
    while (!ready && n < 200) begin
      if (pred_taken !== 1'b0) bad++;
      @(posedge clk);
      #1;
      n++;
    end
    lk_valid = 1'b0;
    tests++;
    if (n !== 64) begin fails++; $display("FAIL reset_init_len got=%0d want=64", n); end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL reset_pred_in_init got=%0d want=0", bad); end
    tests++;
    if (stat_lookups !== 8'd0 || stat_mispred !== 8'd0) begin
      fails++;
      $display("FAIL reset_stats got=%0d/%0d want=0/0", stat_lookups, stat_mispred);
    end
  endtask

  task automatic test_alloc();
    upd(32'h100, 1'b1, 32'h80);
    lk(32'h100);
    tests++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      fails++;
      $display("FAIL alloc_lookup got=%0b/%h want=1/00000080", pred_taken, pred_target);
    end
    tick();
  endtask

  task automatic test_counter();
    upd(32'h100, 1'b0, 32'h0);
    lk(32'h100);
    tests++;
    if (pred_taken !== 1'b0) begin fails++; $display("FAIL cnt_1 got=%0b want=0", pred_taken); end
    tick();
    upd(32'h100, 1'b0, 32'h0);
    lk(32'h100);
    tests++;
    if (pred_taken !== 1'b0) begin fails++; $display("FAIL cnt_0 got=%0b want=0", pred_taken); end
    tick();
    for (int i = 0; i < 5; i++) upd(32'h100, 1'b1, 32'h84);
    upd(32'h100, 1'b0, 32'h0);
    lk(32'h100);
    tests++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h84) begin
      fails++;
      $display("FAIL cnt_sat_hi got=%0b/%h want=1/00000084", pred_taken, pred_target);
    end
    tick();
    upd(32'h100, 1'b0, 32'h0);
    lk(32'h100);
    tests++;
    if (pred_taken !== 1'b0) begin fails++; $display("FAIL cnt_down got=%0b want=0", pred_taken); end
    tick();
  endtask

  task automatic test_alias();
    upd(32'h100, 1'b1, 32'h80);
    upd(32'h200, 1'b1, 32'h40);
    lk(32'h100);
    tests++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      fails++;
      $display("FAIL alias_old got=%0b/%h want=0/00000000", pred_taken, pred_target);
    end
    tick();
    lk(32'h200);
    tests++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h40) begin
      fails++;
      $display("FAIL alias_new got=%0b/%h want=1/00000040", pred_taken, pred_target);
    end
    tick();
  endtask

  task automatic test_same_cycle();
    upd_valid   = 1'b1;
    upd_pc      = 32'h300;
    upd_taken   = 1'b1;
    upd_target  = 32'h1c0;
    upd_mispred = 1'b0;
    lk(32'h300);
    tests++;
    if (pred_taken !== 1'b0) begin fails++; $display("FAIL same_cyc_now got=%0b want=0", pred_taken); end
    tick();
    lk(32'h300);
    tests++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h1c0) begin
      fails++;
      $display("FAIL same_cyc_next got=%0b/%h want=1/000001c0", pred_taken, pred_target);
    end
    tick();
    // Miss with not-taken must not disturb the aliased entry.
    upd(32'h100, 1'b0, 32'h0);
    lk(32'h300);
    tests++;
    if (pred_taken !== 1'b1) begin fails++; $display("FAIL miss_nt_nowrite got=%0b want=1", pred_taken); end
    tick();
    tests++;
    if (stat_lookups !== exp_lk[7:0]) begin
      fails++;
      $display("FAIL stat_lookups got=%0d want=%0d", stat_lookups, exp_lk);
    end
  endtask

  task automatic test_flush_stats();
    int n = 0;
    upd(32'h104, 1'b1, 32'h20);
    upd_valid   = 1'b1;
    upd_pc      = 32'h408;
    upd_taken   = 1'b0;
    upd_mispred = 1'b1;
    for (int i = 0; i < 260; i++) @(posedge clk);
    #1;
    upd_valid = 1'b0;
    tests++;
    if (stat_mispred !== 8'hff) begin
      fails++;
      $display("FAIL mispred_sat got=%0d want=255", stat_mispred);
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    lk_valid  = 1'b1;
    lk_pc     = 32'h300;
    upd_valid = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    while (!ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    lk_valid  = 1'b0;
    upd_valid = 1'b0;
    tests++;
    if (n !== 64) begin fails++; $display("FAIL flush_init_len got=%0d want=64", n); end
    tests++;
    if (stat_mispred !== 8'hff || stat_lookups !== exp_lk[7:0]) begin
      fails++;
      $display("FAIL flush_stats got=%0d/%0d want=255/%0d", stat_mispred, stat_lookups, exp_lk);
    end
    lk(32'h300);
    tests++;
    if (pred_taken !== 1'b0) begin fails++; $display("FAIL flush_empty0 got=%0b want=0", pred_taken); end
    tick();
    lk(32'h104);
    tests++;
    if (pred_taken !== 1'b0) begin fails++; $display("FAIL flush_empty1 got=%0b want=0", pred_taken); end
    tick();
    upd_valid   = 1'b1;
    upd_pc      = 32'h408;
    upd_taken   = 1'b0;
    upd_mispred = 1'b1;
    tick();
    tests++;
    if (stat_mispred !== 8'hff) begin
      fails++;
      $display("FAIL mispred_stays_sat got=%0d want=255", stat_mispred);
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; lk_valid = 1'b0; lk_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_mispred = 1'b0;
    @(negedge clk);
    test_reset();
    test_alloc();
    test_counter();
    test_alias();
    test_same_cycle();
    test_flush_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
